uart_serial_tx: RTL and testbench

Serial UART transmitter: the line-side end of the CPU UART controller's transmit path. Accepts one byte per `uart_start` pulse from the controller's transmit queue and shifts it out LSB-first on `txd` as a standard 8-N-1 frame, with optional parity. Reports `uart_busy` so the controller issues the next byte only once the line is free.

---
 rtl/uart_serial_tx.sv | 157 +++++++++++++++
 tb/tb_uart_serial_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_serial_tx.sv
// uart_serial_tx: line-side UART transmitter.
// Accepts one byte per uart_start pulse while idle and shifts it out LSB-first
// as an 8-N-1 frame on txd, holding uart_busy high until the stop bit ends.
// Optional feature macro: UART_TX_PARITY_EN adds a parity bit (even/odd chosen
// by PARITY_ODD) between the last data bit and the stop bit.
module uart_serial_tx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_start,
  input  logic [7:0] uart_tx,
  output logic       uart_busy,
  output logic       txd
);

  localparam int DIVISOR = CLK_FREQ / BAUD;
  localparam int CNT_W   = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  // A bit period shorter than two clocks cannot be produced by this counter,
  // and the parity sense is a single bit.
  generate
    if (DIVISOR < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_config
      $error("uart_serial_tx: CLK_FREQ/BAUD must be >= 2 and PARITY_ODD must be 0 or 1");
    end
  endgenerate

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_done;
`ifdef UART_TX_PARITY_EN
  // Parity of the byte captured at acceptance; the shift register is consumed
  // during the data bits, so the parity is kept separately.
  logic             par_bit;
`endif

  assign bit_done = (cnt == CNT_LAST);

  // Frame sequencer: baud counting, bit shifting and registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      txd       <= 1'b1;
      uart_busy <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          txd       <= 1'b1;
          uart_busy <= 1'b0;
          if (uart_start) begin
            shift     <= uart_tx;
            cnt       <= '0;
            bit_idx   <= '0;
            state     <= S_START;
            txd       <= 1'b0;
            uart_busy <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_bit   <= (^uart_tx) ^ (PARITY_ODD != 0);
`endif
          end
        end

        S_START: begin
          if (bit_done) begin
            cnt   <= '0;
            state <= S_DATA;
            txd   <= shift[0];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (bit_done) begin
            cnt     <= '0;
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              txd   <= par_bit;
`else
              state <= S_STOP;
              txd   <= 1'b1;
`endif
            end else begin
              txd <= shift[1];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            cnt   <= '0;
            state <= S_STOP;
            txd   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          // busy drops on the edge ending the stop bit; the next acceptance
          // can happen one edge later from IDLE.
          if (bit_done) begin
            cnt       <= '0;
            state     <= S_IDLE;
            uart_busy <= 1'b0;
            txd       <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state     <= S_IDLE;
          cnt       <= '0;
          txd       <= 1'b1;
          uart_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_serial_tx.sv
// tb_uart_serial_tx: scoreboard bench for uart_serial_tx at CLK_FREQ=16, BAUD=1.
// Bytes are queued when driven; a line monitor decodes each frame from txd
// and compares it against the head of the queue.
`timescale 1ns/1ps
module tb_uart_serial_tx;

  localparam int CLK_FREQ   = 16;
  localparam int BAUD       = 1;
  localparam int D          = 16;
  localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_LEN = NB * D;
  localparam int MAXLEN    = (NB + 2) * D;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       uart_start = 1'b0;
  logic [7:0] uart_tx    = 8'h00;
  logic       uart_busy;
  logic       txd;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  bit         mon_skip = 1'b0;
  logic [7:0] sb[$];

  uart_serial_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_start(uart_start),
    .uart_tx   (uart_tx),
    .uart_busy (uart_busy),
    .txd       (txd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit expect_it);
    @(negedge clk);
    uart_tx    = b;
    uart_start = 1'b1;
    if (expect_it) sb.push_back(b);
    @(negedge clk);
    uart_start = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, output int t);
    int n;
    n = 0;
    while (uart_busy !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_busy_in_time", 32'(n < budget), 32'd1);
    t = cyc;
  endtask

  task automatic wait_idle();
    int t;
    wait_busy(1'b0, 2 * FRAME_LEN, t);
  endtask

  // Line monitor: captures txd for every busy period and scores the frame.
  initial begin : monitor
    logic          tx_s[MAXLEN];
    logic [NB-1:0] bits;
    logic [7:0]    exp;
    int            len;
    int            unstable;
    bit            skip;
    forever begin
      @(negedge clk);
      if (uart_busy === 1'b1) begin
        skip = mon_skip;
        len  = 0;
        while (uart_busy === 1'b1 && len < MAXLEN) begin
          tx_s[len] = txd;
          len++;
          @(negedge clk);
        end
        if (!skip) begin
          check("busy_len", len, FRAME_LEN);
          check("sb_pending", 32'(sb.size() > 0), 32'd1);
          if (len == FRAME_LEN && sb.size() > 0) begin
            exp      = sb.pop_front();
            unstable = 0;
            for (int b = 0; b < NB; b++) begin
              bits[b] = tx_s[b*D];
              for (int k = 1; k < D; k++)
                if (tx_s[b*D+k] !== bits[b]) unstable++;
            end
            check("bit_stable", unstable, 0);
            check("start_bit", 32'(bits[0]), 32'd0);
            check("data", 32'(bits[8:1]), 32'(exp));
`ifdef UART_TX_PARITY_EN
            check("parity", 32'(bits[9]), 32'((^exp) ^ (PARITY_ODD != 0)));
`endif
            check("stop_bit", 32'(bits[NB-1]), 32'd1);
          end else if (sb.size() > 0) begin
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int t1;
    int t2;
    int tf;

    // Reset held two cycles with a start request present.
    rst        = 1'b1;
    uart_start = 1'b1;
    uart_tx    = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_busy", 32'(uart_busy), 32'd0);
    end
    rst        = 1'b0;
    uart_start = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_busy", 32'(uart_busy), 32'd0);
    check("post_rst_txd", 32'(txd), 32'd1);

    // Single byte 0x55.
    send_byte(8'h55, 1'b1);
    check("accept_busy", 32'(uart_busy), 32'd1);
    check("accept_txd", 32'(txd), 32'd0);
    wait_idle();

    // Start request mid-frame is ignored.
    send_byte(8'hA3, 1'b1);
    repeat (39) @(negedge clk);
    uart_tx    = 8'hFF;
    uart_start = 1'b1;
    @(negedge clk);
    uart_start = 1'b0;
    check("ign_busy", 32'(uart_busy), 32'd1);
    wait_idle();
    repeat (40) @(negedge clk);
    check("ign_idle_busy", 32'(uart_busy), 32'd0);
    check("ign_idle_txd", 32'(txd), 32'd1);

    // Back-to-back with uart_start held high.
    @(negedge clk);
    uart_tx    = 8'h00;
    uart_start = 1'b1;
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    wait_busy(1'b1, 4, t1);
    uart_tx = 8'hFF;
    wait_busy(1'b0, 2 * FRAME_LEN, tf);
    wait_busy(1'b1, 4, t2);
    uart_start = 1'b0;
    check("stop_to_start", t2 - t1 - (NB - 1) * D, D + 1);
    wait_idle();

    // Reset at clock 70 of a 0x0F frame.
    mon_skip = 1'b1;
    send_byte(8'h0F, 1'b0);
    repeat (69) @(negedge clk);
    check("midrst_busy_pre", 32'(uart_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_txd", 32'(txd), 32'd1);
    check("midrst_busy", 32'(uart_busy), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    mon_skip = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_idle", 32'(uart_busy), 32'd0);
    send_byte(8'h81, 1'b1);
    wait_idle();

    // Further patterns including the parity reference byte.
    send_byte(8'h07, 1'b1);
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
